sys_ctrl: RTL and testbench

//  Command sequencer between the UART receive path and the register file / ALU.

---
 rtl/sys_ctrl_pkg.sv | 18 +
 rtl/sys_ctrl_tx_seq.sv | 86 ++++++++
 rtl/sys_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sys_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the UART command sequencer: opcodes, operand register
// addresses and FSM state encodings.
package sys_ctrl_pkg;
  localparam logic [7:0] OP_WR     = 8'hAA;
  localparam logic [7:0] OP_RD     = 8'hBB;
  localparam logic [7:0] OP_ALU    = 8'hCC;
  localparam logic [7:0] OP_ALU_ST = 8'hDD;

  localparam int REG_OPA = 0;
  localparam int REG_OPB = 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT,
    ST_OPA, ST_OPB, ST_FUN, ST_ALU_WAIT, ST_TX
  } state_e;

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} tx_state_e;
endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// Response serializer: shifts out up to ALU_W bits as DATA_W bytes, LSB first,
// using the TX_Busy request/accept handshake; pulses done_o after the last byte.
module sys_ctrl_tx_seq
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ALU_W  = 16,
  parameter int NB_W   = 2
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              load_i,
  input  logic [ALU_W-1:0]  data_i,
  input  logic [NB_W-1:0]   nbytes_i,
  input  logic              tx_busy_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_vld_o,
  output logic              done_o
);
  tx_state_e         st_q, st_d;
  logic [ALU_W-1:0]  sh_q, sh_d;
  logic [NB_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              vld_q, vld_d, done_q, done_d;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      st_q   <= TX_IDLE;
      sh_q   <= '0;
      cnt_q  <= '0;
      dat_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      dat_q  <= dat_d;
      vld_q  <= vld_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    dat_d  = dat_q;
    vld_d  = vld_q;
    done_d = 1'b0;
    case (st_q)
      TX_IDLE: if (load_i) begin
        sh_d  = data_i;
        cnt_d = nbytes_i;
        st_d  = TX_REQ;
      end
      TX_REQ: begin
        // Data is only updated while the request is low, so it never moves under TX_D_VLD.
        if (!vld_q) begin
          if (!tx_busy_i) begin
            dat_d = sh_q[DATA_W-1:0];
            vld_d = 1'b1;
          end
        end else if (tx_busy_i) begin
          vld_d = 1'b0;
          sh_d  = sh_q >> DATA_W;
          cnt_d = cnt_q - 1'b1;
          st_d  = TX_WAIT;
        end
      end
      TX_WAIT: if (!tx_busy_i) begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          st_d   = TX_IDLE;
        end else begin
          st_d = TX_REQ;
        end
      end
      default: st_d = TX_IDLE;
    endcase
  end

  assign tx_data_o = dat_q;
  assign tx_vld_o  = vld_q;
  assign done_o    = done_q;
endmodule

// File: rtl/sys_ctrl.sv
// Command sequencer between UART RX and the register file / ALU: decodes framed
// commands, issues single-cycle strobes, gates the ALU clock and returns responses.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int ALU_W   = 16,
  parameter int FUN_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RdData_Valid,
  input  logic [ALU_W-1:0]  ALU_OUT,
  input  logic              OUT_Valid,
  input  logic              TX_Busy,
  output logic              WrEn,
  output logic              RdEn,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WrData,
  output logic              ALU_EN,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              CLK_EN,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD
);
  localparam int NBYTES = ALU_W / DATA_W;
  localparam int NB_W   = $clog2(NBYTES + 1);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [FUN_W-1:0]  fun_q, fun_d;
  logic              wren_q, wren_d, rden_q, rden_d;
  logic              aluen_q, aluen_d, clken_q, clken_d;
  logic              timed, tx_load, tx_done;
  logic [ALU_W-1:0]  tx_data;
  logic [NB_W-1:0]   tx_nbytes;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      fun_q   <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      aluen_q <= 1'b0;
      clken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      fun_q   <= fun_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      aluen_q <= aluen_d;
      clken_q <= clken_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    fun_d     = fun_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    aluen_d   = 1'b0;
    clken_d   = clken_q;
    tx_load   = 1'b0;
    tx_data   = '0;
    tx_nbytes = '0;
    timed     = (state_q != ST_IDLE) && (state_q != ST_TX);
    if (timed) cnt_d = cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          OP_WR:     state_d = ST_WR_ADDR;
          OP_RD:     state_d = ST_RD_ADDR;
          OP_ALU:    state_d = ST_OPA;
          OP_ALU_ST: state_d = ST_FUN;
          default:   state_d = ST_IDLE;
        endcase
      end
      ST_WR_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_W-1:0];
        state_d = ST_WR_DATA;
      end
      ST_WR_DATA: if (RX_D_VLD) begin
        wdat_d  = RX_P_DATA;
        wren_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_W-1:0];
        rden_d  = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (RdData_Valid) begin
        tx_load   = 1'b1;
        tx_data   = ALU_W'(RdData);
        tx_nbytes = NB_W'(1);
        state_d   = ST_TX;
      end
      ST_OPA: if (RX_D_VLD) begin
        addr_d  = ADDR_W'(REG_OPA);
        wdat_d  = RX_P_DATA;
        wren_d  = 1'b1;
        state_d = ST_OPB;
      end
      ST_OPB: if (RX_D_VLD) begin
        addr_d  = ADDR_W'(REG_OPB);
        wdat_d  = RX_P_DATA;
        wren_d  = 1'b1;
        state_d = ST_FUN;
      end
      ST_FUN: if (RX_D_VLD) begin
        fun_d   = RX_P_DATA[FUN_W-1:0];
        aluen_d = 1'b1;
        clken_d = 1'b1;
        state_d = ST_ALU_WAIT;
      end
      ST_ALU_WAIT: if (OUT_Valid) begin
        clken_d   = 1'b0;
        tx_load   = 1'b1;
        tx_data   = ALU_OUT;
        tx_nbytes = NB_W'(NBYTES);
        state_d   = ST_TX;
      end
      ST_TX: if (tx_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Every accepted byte or response moves the FSM, so a state change restarts the idle count.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (timed && cnt_q == CNT_W'(TIMEOUT - 1)) begin
      state_d = ST_IDLE;
      clken_d = 1'b0;
      cnt_d   = '0;
    end
  end

  sys_ctrl_tx_seq #(
    .DATA_W (DATA_W),
    .ALU_W  (ALU_W),
    .NB_W   (NB_W)
  ) u_tx_seq (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .load_i    (tx_load),
    .data_i    (tx_data),
    .nbytes_i  (tx_nbytes),
    .tx_busy_i (TX_Busy),
    .tx_data_o (TX_P_DATA),
    .tx_vld_o  (TX_D_VLD),
    .done_o    (tx_done)
  );

  assign WrEn    = wren_q;
  assign RdEn    = rden_q;
  assign Address = addr_q;
  assign WrData  = wdat_q;
  assign ALU_EN  = aluen_q;
  assign ALU_FUN = fun_q;
  assign CLK_EN  = clken_q;
endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: register-file / ALU / UART-TX responders, a command-level
// reference model, a vector table, corner-case sequences and random commands.
module tb_sys_ctrl;
  localparam int TIMEOUT = 1024;
  localparam int ALU_LAT = 3;
  localparam int SETTLE  = 60;

  logic       CLK, RST_n;
  logic [7:0] RX_P_DATA, RdData, TX_P_DATA, WrData;
  logic       RX_D_VLD, RdData_Valid, OUT_Valid, TX_Busy;
  logic [15:0] ALU_OUT;
  logic       WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
  logic [3:0] Address, ALU_FUN;

  sys_ctrl #(.DATA_W(8), .ADDR_W(4), .ALU_W(16), .FUN_W(4), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_n(RST_n), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .TX_Busy(TX_Busy), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  initial begin CLK = 0; forever #5 CLK = ~CLK; end

  int checks = 0, failures = 0;
  int acc_dly = 0, busy_len = 2, rd_cnt = 0, alu_cnt = 0;
  logic [7:0]  rf_env[16], rf_m[16];
  logic [11:0] wr_log[$], exp_wr[$];
  logic [7:0]  tx_log[$], exp_tx[$];

  typedef struct { logic [31:0] cmd; int nwr; int ntx; logic [15:0] tx; } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    logic [15:0] x, y;
    x = {8'h00, a}; y = {8'h00, b};
    case (f)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x * y;
      4'd3: return x & y;
      default: return x ^ y;
    endcase
  endfunction

  function automatic int cmd_len(input logic [7:0] op);
    case (op)
      8'hAA: return 3;
      8'hBB: return 2;
      8'hCC: return 4;
      8'hDD: return 2;
      default: return 1;
    endcase
  endfunction

  // Whole-command reference: what register writes and TX bytes a command produces.
  task automatic model_cmd(input logic [31:0] bv);
    logic [7:0] b0, b1, b2, b3;
    logic [15:0] r;
    b0 = bv[31:24]; b1 = bv[23:16]; b2 = bv[15:8]; b3 = bv[7:0];
    exp_wr.delete(); exp_tx.delete();
    case (b0)
      8'hAA: begin rf_m[b1[3:0]] = b2; exp_wr.push_back({b1[3:0], b2}); end
      8'hBB: exp_tx.push_back(rf_m[b1[3:0]]);
      8'hCC: begin
        rf_m[0] = b1; rf_m[1] = b2;
        exp_wr.push_back({4'd0, b1}); exp_wr.push_back({4'd1, b2});
        r = alu_ref(b1, b2, b3[3:0]);
        exp_tx.push_back(r[7:0]); exp_tx.push_back(r[15:8]);
      end
      8'hDD: begin
        r = alu_ref(rf_m[0], rf_m[1], b1[3:0]);
        exp_tx.push_back(r[7:0]); exp_tx.push_back(r[15:8]);
      end
      default: ;
    endcase
  endtask

  task automatic clear_logs();
    wr_log.delete(); tx_log.delete(); rd_cnt = 0; alu_cnt = 0;
  endtask

  task automatic cmp_logs(input string nm);
    chk({nm, ":nwr"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
      chk({nm, ":wr"}, 32'(wr_log[i]), 32'(exp_wr[i]));
    chk({nm, ":ntx"}, 32'(tx_log.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      chk({nm, ":tx"}, 32'(tx_log[i]), 32'(exp_tx[i]));
    clear_logs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK); RX_P_DATA = b; RX_D_VLD = 1'b1;
    @(negedge CLK); RX_D_VLD = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] bv, input int gmax);
    int n;
    n = cmd_len(bv[31:24]);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gmax)) @(negedge CLK);
      send_byte(bv[31-8*i -: 8]);
    end
    repeat (SETTLE) @(negedge CLK);
  endtask

  // Monitor and register-file model
  initial forever begin
    @(negedge CLK);
    if (WrEn) begin wr_log.push_back({Address, WrData}); rf_env[Address] = WrData; end
    if (RdEn) rd_cnt++;
    if (ALU_EN) alu_cnt++;
  end

  // Register-file read port: data two cycles after RdEn
  initial forever begin
    logic [3:0] a;
    @(negedge CLK);
    if (RdEn) begin
      a = Address;
      @(negedge CLK);
      @(negedge CLK); RdData = rf_env[a]; RdData_Valid = 1'b1;
      @(negedge CLK); RdData_Valid = 1'b0;
    end
  end

  // ALU: result ALU_LAT cycles after ALU_EN, operands from registers 0/1
  initial forever begin
    logic [3:0] f;
    @(negedge CLK);
    if (ALU_EN) begin
      f = ALU_FUN;
      repeat (ALU_LAT) @(negedge CLK);
      ALU_OUT = alu_ref(rf_env[0], rf_env[1], f); OUT_Valid = 1'b1;
      @(negedge CLK); OUT_Valid = 1'b0;
    end
  end

  // UART transmitter: accepts after acc_dly cycles, stays busy busy_len cycles
  initial forever begin
    logic [7:0] b;
    @(negedge CLK);
    if (RST_n && TX_D_VLD && !TX_Busy) begin
      b = TX_P_DATA;
      repeat (acc_dly) begin
        @(negedge CLK);
        chk("tx_hold", 32'({TX_D_VLD, TX_P_DATA}), 32'({1'b1, b}));
      end
      tx_log.push_back(b);
      TX_Busy = 1'b1;
      @(negedge CLK);
      chk("tx_drop", 32'(TX_D_VLD), 32'd0);
      repeat (busy_len - 1) @(negedge CLK);
      TX_Busy = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    logic [31:0] r, bv;
    logic [7:0] op;
    RST_n = 0; RX_P_DATA = 0; RX_D_VLD = 0; RdData = 0; RdData_Valid = 0;
    ALU_OUT = 0; OUT_Valid = 0; TX_Busy = 0;
    for (int i = 0; i < 16; i++) begin rf_env[i] = 0; rf_m[i] = 0; end
    repeat (3) @(negedge CLK);
    chk("reset_outputs", 32'({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD}), 32'd0);
    RST_n = 1;
    repeat (2) @(negedge CLK);

    // Write: strobe exactly one cycle after the final byte
    model_cmd(32'hAA053C00);
    send_byte(8'hAA); send_byte(8'h05);
    @(negedge CLK); RX_P_DATA = 8'h3C; RX_D_VLD = 1'b1;
    @(negedge CLK); RX_D_VLD = 1'b0;
    chk("wr_lat", 32'({WrEn, Address, WrData}), 32'({1'b1, 4'h5, 8'h3C}));
    @(negedge CLK); chk("wr_pulse_end", 32'(WrEn), 32'd0);
    repeat (SETTLE) @(negedge CLK);
    cmp_logs("write");

    // Read with slow TX accept: TX_D_VLD held until busy
    acc_dly = 3; busy_len = 3;
    model_cmd(32'hBB050000);
    send_byte(8'hBB);
    @(negedge CLK); RX_P_DATA = 8'h05; RX_D_VLD = 1'b1;
    @(negedge CLK); RX_D_VLD = 1'b0;
    chk("rd_lat", 32'({RdEn, Address}), 32'({1'b1, 4'h5}));
    @(negedge CLK); chk("rd_pulse_end", 32'(RdEn), 32'd0);
    repeat (SETTLE) @(negedge CLK);
    chk("read_byte", tx_log.size() > 0 ? 32'(tx_log[0]) : 32'hDEAD, 32'h3C);
    cmp_logs("read");

    // ALU with operands: clock gate window covers ALU_EN through OUT_Valid
    acc_dly = 1; busy_len = 2;
    model_cmd(32'hCC123400);
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34);
    @(negedge CLK); RX_P_DATA = 8'h00; RX_D_VLD = 1'b1;
    @(negedge CLK); RX_D_VLD = 1'b0;
    chk("alu_start", 32'({ALU_EN, CLK_EN, ALU_FUN}), 32'({1'b1, 1'b1, 4'h0}));
    n = 0; k = 0;
    while (CLK_EN && k < 50) begin n++; @(negedge CLK); k++; end
    chk("clk_en_window", 32'(n), 32'(ALU_LAT + 1));
    repeat (SETTLE) @(negedge CLK);
    chk("alu_en_pulses", 32'(alu_cnt), 32'd1);
    chk("alu_bytes", tx_log.size() == 2 ? 32'({tx_log[1], tx_log[0]}) : 32'hDEAD, 32'h0046);
    cmp_logs("alu");

    // Vector table
    tbl[0]  = '{32'hAA053C00, 1, 0, 16'h0000};
    tbl[1]  = '{32'hBB050000, 0, 1, 16'h003C};
    tbl[2]  = '{32'hCC123400, 2, 2, 16'h0046};
    tbl[3]  = '{32'h7F000000, 0, 0, 16'h0000};
    tbl[4]  = '{32'hDD010000, 0, 2, 16'hFFDE};
    tbl[5]  = '{32'hAAF57700, 1, 0, 16'h0000};
    tbl[6]  = '{32'hBB250000, 0, 1, 16'h0077};
    tbl[7]  = '{32'hCC030402, 2, 2, 16'h000C};
    tbl[8]  = '{32'hDD130000, 0, 2, 16'h0000};
    tbl[9]  = '{32'hDD040000, 0, 2, 16'h0007};
    tbl[10] = '{32'hBB000000, 0, 1, 16'h0003};
    for (int i = 0; i < 11; i++) begin
      model_cmd(tbl[i].cmd);
      run_cmd(tbl[i].cmd, 2);
      chk($sformatf("tbl%0d:nwr", i), 32'(wr_log.size()), 32'(tbl[i].nwr));
      chk($sformatf("tbl%0d:ntx", i), 32'(tx_log.size()), 32'(tbl[i].ntx));
      for (int j = 0; j < tbl[i].ntx && j < tx_log.size(); j++)
        chk($sformatf("tbl%0d:tx%0d", i, j), 32'(tx_log[j]), 32'(tbl[i].tx[8*j +: 8]));
      clear_logs();
    end

    // Timeout: a long but legal gap is accepted, a gap past TIMEOUT aborts
    model_cmd(32'hAA055A00);
    send_byte(8'hAA); send_byte(8'h05);
    repeat (TIMEOUT - 20) @(negedge CLK);
    send_byte(8'h5A);
    repeat (SETTLE) @(negedge CLK);
    cmp_logs("long_gap");
    send_byte(8'hAA); send_byte(8'h05);
    repeat (TIMEOUT + 4) @(negedge CLK);
    send_byte(8'h99);
    repeat (SETTLE) @(negedge CLK);
    chk("abort_no_write", 32'(wr_log.size()), 32'd0);
    clear_logs();
    model_cmd(32'hBB050000);
    run_cmd(32'hBB050000, 0);
    cmp_logs("after_abort");

    // Robustness: junk opcode, bytes during ALU_WAIT (one coincident with OUT_Valid) and TX
    send_byte(8'h7F);
    repeat (10) @(negedge CLK);
    chk("junk_opcode", 32'({8'(wr_log.size()), 8'(rd_cnt), 8'(alu_cnt), 8'(tx_log.size())}), 32'd0);
    model_cmd(32'hCC030500);
    send_byte(8'hCC); send_byte(8'h03); send_byte(8'h05); send_byte(8'h00);
    k = 0;
    while (!ALU_EN && k < 20) begin @(negedge CLK); k++; end
    chk("alu_en_seen", 32'(ALU_EN), 32'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h05);
    repeat (SETTLE) @(negedge CLK);
    chk("robust_strobes", 32'({8'(alu_cnt), 8'(rd_cnt)}), 32'h0100);
    cmp_logs("robust");
    model_cmd(32'hBB000000);
    run_cmd(32'hBB000000, 1);
    cmp_logs("robust_after");

    // Reset during TX_WAIT
    acc_dly = 0; busy_len = 8;
    send_byte(8'hBB); send_byte(8'h05);
    k = 0;
    while (!TX_Busy && k < 100) begin @(negedge CLK); k++; end
    chk("tx_busy_seen", 32'(TX_Busy), 32'd1);
    @(negedge CLK);
    #2 RST_n = 0;
    #1 chk("reset_async", 32'({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD}), 32'd0);
    @(negedge CLK); RST_n = 1;
    repeat (SETTLE) @(negedge CLK);
    clear_logs();
    busy_len = 2;
    model_cmd(32'hAA01FF00);
    run_cmd(32'hAA01FF00, 0);
    cmp_logs("post_reset");

    // Random commands against the model
    for (int i = 0; i < 60; i++) begin
      r = $urandom();
      case ($urandom_range(0, 4))
        0: op = 8'hAA;
        1: op = 8'hBB;
        2: op = 8'hCC;
        3: op = 8'hDD;
        default: begin
          op = 8'($urandom_range(0, 255));
          while (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD) op = 8'($urandom_range(0, 255));
        end
      endcase
      bv = {op, r[23:0]};
      acc_dly = $urandom_range(0, 3);
      busy_len = $urandom_range(1, 5);
      model_cmd(bv);
      run_cmd(bv, 3);
      cmp_logs($sformatf("rnd%0d_%08h", i, bv));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
